gpio_control_wb: RTL and testbench

Wishbone slave for per-pin GPIO ownership, sitting directly downstream of the Wishbone interconnect on the 0x3200_XXXX window. Holds a 4-bit owner field for each of the 38 user GPIOs in five memory-mapped registers. Routes the selected team's `out`/`oeb` onto the chip pads through a registered output stage. Returns read data and a single-cycle ack to the interconnect.

---
 rtl/gpio_control_pkg.sv | 29 ++
 rtl/gpio_pin_mux.sv | 33 +++
 rtl/gpio_control_wb.sv | 147 ++++++++++++++
 tb/tb_gpio_control_wb.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_control_pkg.sv
// gpio_control_pkg
// Shared constants, FSM state type and register helper for the GPIO
// ownership Wishbone slave.
//   NUM_PINS       - user GPIOs routed by the block
//   SEL_W          - width of one per-pin owner field
//   NUM_SEL_REGS   - number of memory-mapped owner registers
//   SEL4_USED_BITS - implemented bits of the last owner register
package gpio_control_pkg;

    localparam int NUM_PINS       = 38;
    localparam int SEL_W          = 4;
    localparam int NUM_SEL_REGS   = 5;
    localparam int SEL4_USED_BITS = 24;

    typedef enum logic {
        IDLE,
        ACK
    } gpio_wb_state_t;

    // Writable-bit mask of an owner register. The last register only holds
    // pins 32..37, so its upper byte is forced to read as zero.
    function automatic logic [31:0] sel_reg_mask(input logic [2:0] idx);
        if (idx == 3'(NUM_SEL_REGS - 1)) begin
            return {{(32 - SEL4_USED_BITS){1'b0}}, {SEL4_USED_BITS{1'b1}}};
        end
        return '1;
    endfunction

endpackage

// File: rtl/gpio_pin_mux.sv
// gpio_pin_mux
// Combinational owner select for a single pad.
//   owner    in  SEL_W      owner field of this pin (0 or > NUM_TEAMS = unassigned)
//   team_out in  NUM_TEAMS  this pin's out bit from every team
//   team_oeb in  NUM_TEAMS  this pin's oeb bit from every team
//   pad_out  out 1          selected out value (0 when unassigned)
//   pad_oeb  out 1          selected oeb value (1 when unassigned)
module gpio_pin_mux
    import gpio_control_pkg::*;
#(
    parameter int NUM_TEAMS = 1
) (
    input  logic [SEL_W-1:0]   owner,
    input  logic [NUM_TEAMS:1] team_out,
    input  logic [NUM_TEAMS:1] team_oeb,
    output logic               pad_out,
    output logic               pad_oeb
);

    // Default is the safe unassigned pad (input, driven low); any owner
    // value that matches no team falls through to it.
    always_comb begin
        pad_out = 1'b0;
        pad_oeb = 1'b1;
        for (int t = 1; t <= NUM_TEAMS; t++) begin
            if (owner == SEL_W'(t)) begin
                pad_out = team_out[t];
                pad_oeb = team_oeb[t];
            end
        end
    end

endmodule

// File: rtl/gpio_control_wb.sv
// gpio_control_wb
// Wishbone slave holding a 4-bit owner field per user GPIO and routing the
// owning team's out/oeb onto the pads through a registered output stage.
//   clk, nrst          clock, asynchronous active-low reset
//   wbs_*_i            Wishbone request (stb, cyc, we, sel, adr, dat)
//   wbs_dat_o          read data, zero whenever ack is low
//   wbs_ack_o          single-cycle ack
//   designs_gpio_out   per-team pad output values
//   designs_gpio_oeb   per-team pad output-enable-bar
//   io_out, io_oeb     registered pad outputs
module gpio_control_wb
    import gpio_control_pkg::*;
#(
    parameter int NUM_TEAMS = 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic                          wbs_stb_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_we_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    output logic [31:0]                   wbs_dat_o,
    output logic                          wbs_ack_o,
    input  logic [NUM_TEAMS:1][NUM_PINS-1:0] designs_gpio_out,
    input  logic [NUM_TEAMS:1][NUM_PINS-1:0] designs_gpio_oeb,
    output logic [NUM_PINS-1:0]           io_out,
    output logic [NUM_PINS-1:0]           io_oeb
);

    gpio_wb_state_t state, next_state;

    logic [31:0]               sel_regs [NUM_SEL_REGS];
    logic [31:0]               rdata_q;
    logic [31:0]               rd_data;
    logic [31:0]               wr_merge;
    logic [2:0]                reg_idx;
    logic                      mapped;
    logic                      accept;
    logic [NUM_PINS*SEL_W-1:0] owners;
    logic [NUM_PINS-1:0]       pad_out_d;
    logic [NUM_PINS-1:0]       pad_oeb_d;
    logic                      unused_bits;

    // Only adr[15:5] == 0 with a register index below 5 hits a real register.
    assign reg_idx = wbs_adr_i[4:2];
    assign mapped  = (wbs_adr_i[15:5] == 11'd0) && (reg_idx < 3'(NUM_SEL_REGS));

    assign unused_bits = ^{wbs_adr_i[31:16], wbs_adr_i[1:0],
                           sel_regs[NUM_SEL_REGS-1][31:SEL4_USED_BITS]};

    // Request acceptance happens only from IDLE, so a strobe still high in
    // the ack cycle is ignored and transactions are at least two cycles apart.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (wbs_stb_i && wbs_cyc_i) begin
                    accept     = 1'b1;
                    next_state = ACK;
                end
            end
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM state register; reset in the ack cycle drops ack immediately.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Read mux and byte-lane merge of the write data with the old contents.
    always_comb begin
        rd_data  = '0;
        wr_merge = '0;
        if (mapped) begin
            rd_data = sel_regs[reg_idx];
        end
        for (int j = 0; j < 4; j++) begin
            wr_merge[8*j +: 8] = wbs_sel_i[j] ? wbs_dat_i[8*j +: 8] : rd_data[8*j +: 8];
        end
    end

    // Read data is captured from the pre-write contents at the accepting
    // edge; writes to unmapped addresses are dropped but still acked.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < NUM_SEL_REGS; i++) begin
                sel_regs[i] <= '0;
            end
            rdata_q <= '0;
        end else if (accept) begin
            rdata_q <= rd_data;
            if (wbs_we_i && mapped) begin
                sel_regs[reg_idx] <= wr_merge & sel_reg_mask(reg_idx);
            end
        end
    end

    assign wbs_ack_o = (state == ACK);
    assign wbs_dat_o = wbs_ack_o ? rdata_q : '0;

    // Owner field of pin p lands at owners[4p+3:4p].
    assign owners = {sel_regs[4][SEL4_USED_BITS-1:0], sel_regs[3],
                     sel_regs[2], sel_regs[1], sel_regs[0]};

    // One mux per pin; the per-team bits are transposed from the team-major
    // input arrays into a pin-major vector for each mux.
    for (genvar p = 0; p < NUM_PINS; p++) begin : g_pin
        logic [NUM_TEAMS:1] team_out;
        logic [NUM_TEAMS:1] team_oeb;

        for (genvar t = 1; t <= NUM_TEAMS; t++) begin : g_team
            assign team_out[t] = designs_gpio_out[t][p];
            assign team_oeb[t] = designs_gpio_oeb[t][p];
        end

        gpio_pin_mux #(
            .NUM_TEAMS (NUM_TEAMS)
        ) u_mux (
            .owner    (owners[SEL_W*p +: SEL_W]),
            .team_out (team_out),
            .team_oeb (team_oeb),
            .pad_out  (pad_out_d[p]),
            .pad_oeb  (pad_oeb_d[p])
        );
    end

    // Pad output stage; reset leaves every pad as an undriven input.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            io_out <= '0;
            io_oeb <= '1;
        end else begin
            io_out <= pad_out_d;
            io_oeb <= pad_oeb_d;
        end
    end

endmodule

// File: tb/tb_gpio_control_wb.sv
// tb_gpio_control_wb
// Directed self-checking bench for gpio_control_wb with three teams.
module tb_gpio_control_wb;

    localparam int NT = 3;

    logic              clk;
    logic              nrst;
    logic              wbs_stb_i;
    logic              wbs_cyc_i;
    logic              wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [31:0]       wbs_adr_i;
    logic [31:0]       wbs_dat_i;
    logic [31:0]       wbs_dat_o;
    logic              wbs_ack_o;
    logic [NT:1][37:0] team_out;
    logic [NT:1][37:0] team_oeb;
    logic [37:0]       io_out;
    logic [37:0]       io_oeb;

    int          pass_count  = 0;
    int          check_count = 0;
    logic [31:0] rdata;
    logic [37:0] oeb_at_accept;
    logic [5:0]  ack_pattern;
    logic [31:0] b2b_data;

    gpio_control_wb #(
        .NUM_TEAMS (NT)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .wbs_stb_i        (wbs_stb_i),
        .wbs_cyc_i        (wbs_cyc_i),
        .wbs_we_i         (wbs_we_i),
        .wbs_sel_i        (wbs_sel_i),
        .wbs_adr_i        (wbs_adr_i),
        .wbs_dat_i        (wbs_dat_i),
        .wbs_dat_o        (wbs_dat_o),
        .wbs_ack_o        (wbs_ack_o),
        .designs_gpio_out (team_out),
        .designs_gpio_oeb (team_oeb),
        .io_out           (io_out),
        .io_oeb           (io_oeb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // One Wishbone transaction: drive at negedge, expect ack one edge later,
    // then expect ack (and read data) to be low the following cycle.
    task automatic apply_stimulus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                                  input logic [3:0] sel, output logic [31:0] rd,
                                  output logic [37:0] oeb_acc);
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
        @(posedge clk);
        #1;
        check_output("ack_high", 64'(wbs_ack_o), 64'd1);
        rd      = wbs_dat_o;
        oeb_acc = io_oeb;
        @(negedge clk);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(posedge clk);
        #1;
        check_output("ack_single_cycle", 64'(wbs_ack_o), 64'd0);
        check_output("dat_zero_no_ack", 64'(wbs_dat_o), 64'd0);
    endtask

    initial begin
        nrst      = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = 32'h0;
        wbs_dat_i = 32'h0;
        team_out[1] = 38'h15_5555_5555;
        team_oeb[1] = 38'h2A_AAAA_AAAA;
        team_out[2] = 38'h2A_AAAA_AAAA;
        team_oeb[2] = 38'h00_0000_0000;
        team_out[3] = 38'h3F_FFFF_FFFF;
        team_oeb[3] = 38'h00_0000_0000;

        // Reset state
        #12;
        check_output("rst_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check_output("rst_io_out", 64'(io_out), 64'h0);
        check_output("rst_ack", 64'(wbs_ack_o), 64'h0);
        check_output("rst_dat", 64'(wbs_dat_o), 64'h0);
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'(i * 4), 32'h0, 4'hF, rdata, oeb_at_accept);
            check_output($sformatf("rst_read_sel%0d", i), 64'(rdata), 64'h0);
        end

        // Write/readback with routing
        $display("[TB] write SEL0 and check routing");
        apply_stimulus(1'b1, 32'h00, 32'h0000_0021, 4'hF, rdata, oeb_at_accept);
        check_output("pad_not_yet_at_commit", 64'(oeb_at_accept), 64'h3F_FFFF_FFFF);
        check_output("route_io_out", 64'(io_out), 64'h03);
        check_output("route_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFC);
        apply_stimulus(1'b0, 32'h00, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("readback_sel0", 64'(rdata), 64'h21);

        // Team-to-pad goes through exactly one register stage
        @(negedge clk);
        team_out[1] = 38'h15_5555_5554;
        #1;
        check_output("team_change_held", 64'(io_out[0]), 64'd1);
        @(posedge clk);
        #1;
        check_output("team_change_1cyc", 64'(io_out[0]), 64'd0);

        // Byte lanes
        $display("[TB] byte lane writes");
        apply_stimulus(1'b1, 32'h04, 32'h1111_1111, 4'hF, rdata, oeb_at_accept);
        apply_stimulus(1'b1, 32'h04, 32'hFFFF_FFFF, 4'b0100, rdata, oeb_at_accept);
        apply_stimulus(1'b0, 32'h04, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("byte_lane_sel1", 64'(rdata), 64'h11FF_1111);
        check_output("sel1_pads_oeb", 64'(io_oeb[15:8]), 64'hBA);
        check_output("sel1_pads_out", 64'(io_out[15:8]), 64'h45);
        apply_stimulus(1'b1, 32'h04, 32'hFFFF_FFFF, 4'h0, rdata, oeb_at_accept);
        apply_stimulus(1'b0, 32'h04, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("sel_zero_write", 64'(rdata), 64'h11FF_1111);

        // Out-of-range owners and the NUM_TEAMS boundary
        $display("[TB] SEL4 and owner range");
        apply_stimulus(1'b1, 32'h10, 32'hFFFF_FFFF, 4'hF, rdata, oeb_at_accept);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("sel4_readback", 64'(rdata), 64'h00FF_FFFF);
        check_output("sel4_oeb_unassigned", 64'(io_oeb[37:32]), 64'h3F);
        check_output("sel4_out_unassigned", 64'(io_out[37:32]), 64'h0);
        apply_stimulus(1'b1, 32'h10, 32'h0000_0043, 4'hF, rdata, oeb_at_accept);
        check_output("owner3_owner4_oeb", 64'(io_oeb[37:32]), 64'h3E);
        check_output("owner3_owner4_out", 64'(io_out[37:32]), 64'h01);

        // Unmapped addresses and ignored address bits
        $display("[TB] unmapped accesses");
        apply_stimulus(1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, rdata, oeb_at_accept);
        apply_stimulus(1'b0, 32'h14, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("unmapped_read_0x14", 64'(rdata), 64'h0);
        apply_stimulus(1'b1, 32'h20, 32'hFFFF_FFFF, 4'hF, rdata, oeb_at_accept);
        apply_stimulus(1'b0, 32'h00, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("no_alias_0x20", 64'(rdata), 64'h21);
        apply_stimulus(1'b0, 32'h20, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("unmapped_read_0x20", 64'(rdata), 64'h0);
        apply_stimulus(1'b0, 32'h03, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("adr_low_bits_ignored", 64'(rdata), 64'h21);
        apply_stimulus(1'b0, 32'h10, 32'h0, 4'hF, rdata, oeb_at_accept);
        check_output("sel4_after_unmapped", 64'(rdata), 64'h43);

        // Strobe held high: acks only on alternate cycles
        $display("[TB] back-to-back strobe");
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b0;
        wbs_adr_i = 32'h00;
        b2b_data  = 32'h0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            ack_pattern[i] = wbs_ack_o;
            if (i == 0) b2b_data = wbs_dat_o;
        end
        @(negedge clk);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        check_output("b2b_ack_pattern", 64'(ack_pattern), 64'b010101);
        check_output("b2b_read_data", 64'(b2b_data), 64'h21);

        // Reset asserted during the ack cycle of a write
        $display("[TB] reset during ack");
        @(negedge clk);
        wbs_stb_i = 1'b1;
        wbs_cyc_i = 1'b1;
        wbs_we_i  = 1'b1;
        wbs_adr_i = 32'h08;
        wbs_dat_i = 32'h1234_5678;
        wbs_sel_i = 4'hF;
        @(posedge clk);
        #1;
        check_output("rst_ack_before", 64'(wbs_ack_o), 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        check_output("rst_ack_dropped", 64'(wbs_ack_o), 64'd0);
        check_output("rst_mid_io_oeb", 64'(io_oeb), 64'h3F_FFFF_FFFF);
        check_output("rst_mid_io_out", 64'(io_out), 64'h0);
        @(negedge clk);
        wbs_stb_i = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_we_i  = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b0, 32'(i * 4), 32'h0, 4'hF, rdata, oeb_at_accept);
            check_output($sformatf("post_rst_sel%0d", i), 64'(rdata), 64'h0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
